icache_responder: RTL and testbench
===================================

ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 The block SHALL have parameter N_WAY, default `N_WAY (3), the fetch width in instructions per cycle.
REQ-002 The block SHALL have parameter XLEN, default `XLEN (32), the address and instruction width.
REQ-003 The block SHALL have parameter LINES, default 32, the number of direct-mapped lines (8-byte lines, 2 instructions each).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, exposed through the two ports below.
REQ-005 clock  in  1  Sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  Asynchronous, active-low reset.
REQ-007 enable  in  1  Global enable; 0 = stall.
REQ-008 buff2Icache_addr  in  XLEN  PC of the first requested instruction.
REQ-009 buff2Icache_count  in  $clog2(N_WAY)+1  Number of instructions requested.
REQ-010 Icache2buff_addr  out  N_WAY x XLEN  Lane i address.
REQ-011 Icache2buff_data  out  N_WAY x XLEN  Lane i instruction.
REQ-012 Icache2buff_valid  out  N_WAY  Lane i holds a hit instruction.
REQ-013 Icache2buff_hit_count  out  $clog2(N_WAY)+1  Number of valid lanes.
REQ-014 mem_req_valid  out  1  Line-fill request pending.
REQ-015 mem_req_addr  out  XLEN  8-byte-aligned fill address.
REQ-016 mem_req_ready  in  1  Memory accepts the request.
REQ-017 mem_resp_valid  in  1  Fill data valid.
REQ-018 mem_resp_data  in  64  Fill line; bits [31:0] hold the instruction at offset 0, bits [63:32] the one at offset 4.
REQ-019 icache_busy  out  1  The fill FSM is not IDLE.

Function
REQ-020 Lookup SHALL be combinational with zero-cycle latency.
  - Lane address a_i = buff2Icache_addr + 4*i, modulo 2^XLEN (wraps).
  - addr[1:0] ignored.
  - Index = a_i[7:3]; tag = a_i[31:8]; word select = a_i[2].
REQ-021 Icache2buff_addr[i] SHALL equal a_i for every lane, whether the lane is valid or not.
REQ-022 Lane valid rule:
  - Icache2buff_valid[i] = 1 iff enable=1, i < min(count, N_WAY), and lanes 0..i all hit.
  - Valid bits are therefore contiguous from bit 0.
REQ-023 Icache2buff_data[i] SHALL be the selected word when the lane is valid, else 0.
REQ-024 Icache2buff_hit_count SHALL equal the popcount of Icache2buff_valid.
REQ-025 Miss index m: the lowest i < min(count, N_WAY) that misses; none if all requested lanes hit.
REQ-026 The FSM SHALL have states IDLE, REQ and WAIT; icache_busy = (state != IDLE).
REQ-027 IDLE -> REQ:
  - Condition: enable=1 and a miss index m exists.
  - On that edge, fill_addr latches {a_m[31:3], 3'b000}.
REQ-028 REQ:
  - mem_req_valid=1; mem_req_addr=fill_addr, held stable.
  - On mem_req_ready=1 -> WAIT.
REQ-029 WAIT:
  - mem_resp_valid is ignored in IDLE and REQ.
  - The earliest accepted response is the cycle after the request was accepted.
REQ-030 WAIT fill:
  - On mem_resp_valid=1, the line at fill_addr[7:3] takes the data and tag fill_addr[31:8], valid=1; state -> IDLE.
  - A pending miss may re-enter REQ no earlier than the next edge.
REQ-031 The filled line SHALL hit starting the cycle after the response; a same-cycle lookup sees the old contents.
REQ-032 Hit-under-miss: lookups SHALL keep serving hits while in REQ or WAIT, and no second miss is launched.
REQ-033 A fill SHALL complete even if the PC changes, e.g. after a taken branch; the filled line is simply installed.
REQ-034 With enable=0:
  - All lane valid bits are 0 and no new miss is launched.
  - An in-flight REQ/WAIT continues so memory is drained.
REQ-035 A count greater than N_WAY SHALL be clamped to N_WAY; count=0 SHALL give no valid lanes and no miss.
REQ-036 Two lanes in the same line SHALL resolve from one tag compare; a miss on either lane fetches that single line.

Reset
REQ-037 While reset=0 (asynchronous assertion):
  - All line valid bits are cleared and state = IDLE.
  - fill_addr = 0, mem_req_valid = 0, mem_req_addr = 0, icache_busy = 0.
  - Outputs: Icache2buff_valid = 0, hit_count = 0, Icache2buff_data = 0.
REQ-038 A reset during REQ or WAIT SHALL abandon the fill; a later mem_resp_valid SHALL be ignored in IDLE.
REQ-039 Tag and data arrays need not be reset; only the valid bits are.

Verification
REQ-040 Cold miss:
  - Stimulus: after reset, addr=0x0, count=3, enable=1.
  - Response: valid=000, hit_count=0. Next cycle mem_req_valid=1, mem_req_addr=0x0.
  - Then ready, then resp data 0x00000013_00000093: lanes 0 and 1 hit with 0x00000093 and 0x00000013, lane 2 (0x8) misses, valid=011, hit_count=2, and a new request goes to 0x8.
REQ-041 Partial hit:
  - Stimulus: lines 0x0 and 0x8 filled, addr=0x4, count=3.
  - Response: valid=111, hit_count=3, addr lanes = 0x4, 0x8, 0xC; no request issued.
REQ-042 Hole stops the run:
  - Stimulus: line 0x0 filled, 0x8 empty, 0x10 filled; addr=0x0, count=3.
  - Response: valid=011; fill to 0x8 issued, never to 0x10.
REQ-043 Backpressure and stall:
  - Stimulus: hold mem_req_ready=0 for 5 cycles with enable=0 in between.
  - Response: mem_req_valid and mem_req_addr stay stable, valid=000, and exactly one request is accepted.
REQ-044 Reset mid-fill:
  - Stimulus: assert reset in WAIT, release, then pulse mem_resp_valid.
  - Response: no line is written, lookup of that address misses, icache_busy=0 until a new miss.
REQ-045 Wrap-around:
  - Stimulus: addr=0xFFFFFFFC, count=2.
  - Response: lane addresses are 0xFFFFFFFC and 0x00000000, with separate lines looked up and filled.

Source files
------------

// File: rtl/icache_responder_if.sv
// icache_responder_if
// Bundles the fetch-buffer lookup port and the line-fill memory port of the
// instruction cache responder.
//   enable, buff2Icache_addr, buff2Icache_count     : lookup request (to cache)
//   Icache2buff_addr/data/valid/hit_count           : per-lane lookup result
//   mem_req_valid/addr, mem_req_ready               : line-fill request
//   mem_resp_valid/data                             : line-fill response
//   icache_busy                                     : fill in progress
// The slave modport is the cache side; master is the buffer/memory side.
`ifndef N_WAY
`define N_WAY 3
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface icache_responder_if #(
  parameter int N_WAY = `N_WAY,
  parameter int XLEN  = `XLEN
);
  localparam int CW = $clog2(N_WAY) + 1;

  logic                        enable;
  logic [XLEN-1:0]             buff2Icache_addr;
  logic [CW-1:0]               buff2Icache_count;
  logic [N_WAY-1:0][XLEN-1:0]  Icache2buff_addr;
  logic [N_WAY-1:0][XLEN-1:0]  Icache2buff_data;
  logic [N_WAY-1:0]            Icache2buff_valid;
  logic [CW-1:0]               Icache2buff_hit_count;
  logic                        mem_req_valid;
  logic [XLEN-1:0]             mem_req_addr;
  logic                        mem_req_ready;
  logic                        mem_resp_valid;
  logic [63:0]                 mem_resp_data;
  logic                        icache_busy;

  modport master (
    output enable, buff2Icache_addr, buff2Icache_count,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  Icache2buff_addr, Icache2buff_data, Icache2buff_valid,
    input  Icache2buff_hit_count, mem_req_valid, mem_req_addr, icache_busy
  );

  modport slave (
    input  enable, buff2Icache_addr, buff2Icache_count,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output Icache2buff_addr, Icache2buff_data, Icache2buff_valid,
    output Icache2buff_hit_count, mem_req_valid, mem_req_addr, icache_busy
  );
endinterface

// File: rtl/icache_responder.sv
// icache_responder
// Direct-mapped instruction cache with 8-byte lines (two instructions each).
// Lookup of up to N_WAY consecutive instructions is purely combinational; a
// miss on the lowest requested lane launches a single line fill.
// Ports:
//   clock : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : icache_responder_if.slave (lookup + memory fill ports)
//
// Fill FSM
//   state  | meaning
//   S_IDLE | no fill outstanding; a miss with enable=1 launches one
//   S_REQ  | fill request presented, waiting for mem_req_ready
//   S_WAIT | request accepted, waiting for mem_resp_valid
`ifndef N_WAY
`define N_WAY 3
`endif
`ifndef XLEN
`define XLEN 32
`endif

module icache_responder #(
  parameter int N_WAY = `N_WAY,
  parameter int XLEN  = `XLEN,
  parameter int LINES = 32
) (
  input logic               clock,
  input logic               reset,
  icache_responder_if.slave bus
);
  localparam int CW = $clog2(N_WAY) + 1;
  localparam int IW = $clog2(LINES);
  localparam int TW = XLEN - 3 - IW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [LINES-1:0]           r_line_vld;
  logic [TW-1:0]              r_tag  [LINES];
  logic [63:0]                r_data [LINES];
  logic [XLEN-1:0]            r_fill_addr;

  logic [N_WAY-1:0][XLEN-1:0] w_lane_addr;
  logic [N_WAY-1:0][31:0]     w_lane_word;
  logic [N_WAY-1:0][XLEN-1:0] w_lane_data;
  logic [N_WAY-1:0]           w_lane_hit;
  logic [N_WAY-1:0]           w_lane_vld;
  logic [N_WAY:0]             w_run;
  logic [CW-1:0]              w_req_cnt;
  logic [CW-1:0]              w_hit_cnt;
  logic                       w_miss;
  logic [XLEN-1:0]            w_miss_addr;
  logic                       w_launch;
  logic                       w_fill_we;
  logic [IW-1:0]              w_fill_idx;

  // Lanes sharing a line see the same index and tag, so they resolve to the
  // same hit result and a miss on either fetches that one line.
  for (genvar g = 0; g < N_WAY; g++) begin : g_lane
    logic [IW-1:0] w_idx;
    assign w_lane_addr[g] = bus.buff2Icache_addr + XLEN'(4 * g);
    assign w_idx          = w_lane_addr[g][3 +: IW];
    assign w_lane_hit[g]  = r_line_vld[w_idx] &&
                            (r_tag[w_idx] == w_lane_addr[g][XLEN-1 -: TW]);
    assign w_lane_word[g] = w_lane_addr[g][2] ? r_data[w_idx][63:32]
                                              : r_data[w_idx][31:0];
  end

  assign w_req_cnt = (bus.buff2Icache_count > CW'(N_WAY)) ? CW'(N_WAY)
                                                          : bus.buff2Icache_count;

  // w_run[i+1] is set while lanes 0..i are all requested and hit, which makes
  // the valid vector contiguous from lane 0. The miss search ignores enable;
  // enable only gates the launch.
  always_comb begin
    w_run       = '0;
    w_run[0]    = bus.enable;
    w_lane_vld  = '0;
    w_lane_data = '0;
    w_hit_cnt   = '0;
    w_miss      = 1'b0;
    w_miss_addr = '0;
    for (int i = 0; i < N_WAY; i++) begin
      w_run[i+1]    = w_run[i] && (CW'(i) < w_req_cnt) && w_lane_hit[i];
      w_lane_vld[i] = w_run[i+1];
      w_hit_cnt     = w_hit_cnt + CW'(w_run[i+1]);
      if (w_run[i+1]) begin
        w_lane_data[i] = XLEN'(w_lane_word[i]);
      end
      if (!w_miss && (CW'(i) < w_req_cnt) && !w_lane_hit[i]) begin
        w_miss      = 1'b1;
        w_miss_addr = {w_lane_addr[i][XLEN-1:3], 3'b000};
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_fill_we   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.enable && w_miss) begin
          w_state_nxt = S_REQ;
          w_launch    = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          w_state_nxt = S_IDLE;
          w_fill_we   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_fill_idx = r_fill_addr[3 +: IW];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_fill_addr <= '0;
      r_line_vld  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) begin
        r_fill_addr <= w_miss_addr;
      end
      if (w_fill_we) begin
        r_line_vld[w_fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge clock) begin
    if (w_fill_we) begin
      r_tag[w_fill_idx]  <= r_fill_addr[XLEN-1 -: TW];
      r_data[w_fill_idx] <= bus.mem_resp_data;
    end
  end

  assign bus.Icache2buff_addr      = w_lane_addr;
  assign bus.Icache2buff_data      = w_lane_data;
  assign bus.Icache2buff_valid     = w_lane_vld;
  assign bus.Icache2buff_hit_count = w_hit_cnt;
  assign bus.mem_req_valid         = (r_state == S_REQ);
  assign bus.mem_req_addr          = r_fill_addr;
  assign bus.icache_busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;
  localparam int N_WAY = 3;
  localparam int XLEN  = 32;
  localparam int LINES = 32;
  localparam int CW    = $clog2(N_WAY) + 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  icache_responder_if #(.N_WAY(N_WAY), .XLEN(XLEN)) bus ();

  icache_responder #(.N_WAY(N_WAY), .XLEN(XLEN), .LINES(LINES)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference cache: which line address each index holds, and its data.
  bit          m_vld [LINES];
  logic [31:0] m_la  [LINES];
  logic [63:0] m_dat [LINES];
  int          m_phase = 0;   // 0 idle, 1 request outstanding, 2 awaiting data
  logic [31:0] m_fill  = '0;

  logic [N_WAY-1:0] e_valid;
  logic [31:0]      e_addr [N_WAY];
  logic [31:0]      e_data [N_WAY];
  int               e_hcnt;
  bit               e_miss;
  logic [31:0]      e_miss_line;

  function automatic void model_lookup();
    int req; bit run; bit hit; int idx; logic [31:0] a;
    req = (int'(bus.buff2Icache_count) > N_WAY) ? N_WAY : int'(bus.buff2Icache_count);
    run = bus.enable;
    e_valid = '0; e_hcnt = 0; e_miss = 0; e_miss_line = '0;
    for (int i = 0; i < N_WAY; i++) begin
      a   = bus.buff2Icache_addr + 32'(4 * i);
      idx = int'((a / 8) % LINES);
      hit = m_vld[idx] && (m_la[idx] == (a & ~32'h7));
      e_addr[i] = a;
      e_data[i] = '0;
      if (i < req && !hit && !e_miss) begin
        e_miss = 1; e_miss_line = a & ~32'h7;
      end
      run = run && (i < req) && hit;
      e_valid[i] = run;
      if (run) begin
        e_hcnt++;
        e_data[i] = (a % 8 >= 4) ? m_dat[idx][63:32] : m_dat[idx][31:0];
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) m_vld[i] = 0;
    m_phase = 0;
    m_fill  = '0;
  endfunction

  // Advance one clock from a falling edge to the next, stepping the model
  // with the inputs that were present at the rising edge.
  task automatic tick();
    int idx;
    model_lookup();
    @(posedge clock);
    if (reset) begin
      case (m_phase)
        0: if (bus.enable && e_miss) begin m_phase = 1; m_fill = e_miss_line; end
        1: if (bus.mem_req_ready) m_phase = 2;
        default: if (bus.mem_resp_valid) begin
          idx = int'((m_fill / 8) % LINES);
          m_vld[idx] = 1; m_la[idx] = m_fill; m_dat[idx] = bus.mem_resp_data;
          m_phase = 0;
        end
      endcase
    end
    @(negedge clock);
  endtask

  task automatic set_idle_inputs();
    bus.enable = 0; bus.buff2Icache_addr = '0; bus.buff2Icache_count = '0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    set_idle_inputs();
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1;
  endtask

  task automatic set_req(input logic [31:0] addr, input int cnt, input bit en);
    bus.buff2Icache_addr = addr; bus.buff2Icache_count = CW'(cnt); bus.enable = en;
  endtask

  task automatic serve_fill(input logic [63:0] data);
    int t = 0;
    while (!bus.mem_req_valid && t < 20) begin tick(); #1; t++; end
    n_checks++;
    if (!bus.mem_req_valid) begin
      n_fail++; $display("FAIL fill_timeout: mem_req_valid=%b after %0d cycles, required 1", bus.mem_req_valid, t);
    end
    bus.mem_req_ready = 1; tick(); bus.mem_req_ready = 0;
    bus.mem_resp_valid = 1; bus.mem_resp_data = data; tick(); bus.mem_resp_valid = 0;
  endtask

  task automatic test_reset();
    set_idle_inputs();
    set_req(32'h0, 3, 1);
    repeat (2) @(negedge clock);
    #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid: got %b required 000", bus.Icache2buff_valid); end
    n_checks++; if (bus.Icache2buff_hit_count !== CW'(0)) begin n_fail++; $display("FAIL reset_hcnt: got %0d required 0", bus.Icache2buff_hit_count); end
    n_checks++; if (bus.Icache2buff_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h required 0", bus.Icache2buff_data); end
    n_checks++; if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_memreq: got valid=%b addr=%h required 0/0", bus.mem_req_valid, bus.mem_req_addr); end
    n_checks++; if (bus.icache_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.icache_busy); end
    @(negedge clock);
    reset = 1;
  endtask

  task automatic test_cold_miss();
    set_req(32'h0, 3, 1);
    #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b000 || bus.Icache2buff_hit_count !== CW'(0)) begin n_fail++; $display("FAIL cold_first: got valid=%b hcnt=%0d required 000/0", bus.Icache2buff_valid, bus.Icache2buff_hit_count); end
    tick(); #1;
    n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL cold_req0: got valid=%b addr=%h required 1/00000000", bus.mem_req_valid, bus.mem_req_addr); end
    bus.mem_req_ready = 1; tick(); bus.mem_req_ready = 0;
    bus.mem_resp_valid = 1; bus.mem_resp_data = 64'h00000013_00000093;
    #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b000 || bus.icache_busy !== 1'b1) begin n_fail++; $display("FAIL cold_same_cycle: got valid=%b busy=%b required 000/1", bus.Icache2buff_valid, bus.icache_busy); end
    tick(); bus.mem_resp_valid = 0; #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b011 || bus.Icache2buff_hit_count !== CW'(2)) begin n_fail++; $display("FAIL cold_after_fill: got valid=%b hcnt=%0d required 011/2", bus.Icache2buff_valid, bus.Icache2buff_hit_count); end
    n_checks++; if (bus.Icache2buff_data[0] !== 32'h93 || bus.Icache2buff_data[1] !== 32'h13 || bus.Icache2buff_data[2] !== 32'h0) begin n_fail++; $display("FAIL cold_data: got %h required 00000000_00000013_00000093", bus.Icache2buff_data); end
    tick(); #1;
    n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8) begin n_fail++; $display("FAIL cold_req8: got valid=%b addr=%h required 1/00000008", bus.mem_req_valid, bus.mem_req_addr); end
    serve_fill(64'h00000033_00000023);
  endtask

  task automatic test_partial_hit();
    set_req(32'h4, 3, 1);
    #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b111 || bus.Icache2buff_hit_count !== CW'(3)) begin n_fail++; $display("FAIL partial_valid: got valid=%b hcnt=%0d required 111/3", bus.Icache2buff_valid, bus.Icache2buff_hit_count); end
    n_checks++; if (bus.Icache2buff_addr[0] !== 32'h4 || bus.Icache2buff_addr[1] !== 32'h8 || bus.Icache2buff_addr[2] !== 32'hC) begin n_fail++; $display("FAIL partial_addr: got %h required 0000000c_00000008_00000004", bus.Icache2buff_addr); end
    n_checks++; if (bus.Icache2buff_data[0] !== 32'h13 || bus.Icache2buff_data[1] !== 32'h23 || bus.Icache2buff_data[2] !== 32'h33) begin n_fail++; $display("FAIL partial_data: got %h required 00000033_00000023_00000013", bus.Icache2buff_data); end
    tick(); #1;
    n_checks++; if (bus.mem_req_valid !== 1'b0 || bus.icache_busy !== 1'b0) begin n_fail++; $display("FAIL partial_noreq: got req=%b busy=%b required 0/0", bus.mem_req_valid, bus.icache_busy); end
  endtask

  task automatic test_hole();
    int reqs = 0;
    do_reset();
    set_req(32'h0, 1, 1);  serve_fill(64'hAAAA0004_AAAA0000);
    set_req(32'h10, 1, 1); serve_fill(64'hCCCC0014_CCCC0010);
    set_req(32'h0, 3, 1);
    #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b011) begin n_fail++; $display("FAIL hole_valid: got %b required 011", bus.Icache2buff_valid); end
    tick(); #1;
    n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8) begin n_fail++; $display("FAIL hole_req: got valid=%b addr=%h required 1/00000008", bus.mem_req_valid, bus.mem_req_addr); end
    bus.mem_req_ready = 1; tick(); bus.mem_req_ready = 0;
    bus.mem_resp_valid = 1; bus.mem_resp_data = 64'hBBBB000C_BBBB0008; tick(); bus.mem_resp_valid = 0;
    #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b111 || bus.Icache2buff_data[2] !== 32'hBBBB0008) begin n_fail++; $display("FAIL hole_filled: got valid=%b d2=%h required 111/bbbb0008", bus.Icache2buff_valid, bus.Icache2buff_data[2]); end
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      if (bus.mem_req_valid) reqs++;
    end
    n_checks++; if (reqs != 0) begin n_fail++; $display("FAIL hole_no_more_req: got %0d request cycles required 0", reqs); end
  endtask

  task automatic test_backpressure_stall();
    int hs = 0;
    do_reset();
    set_req(32'h40, 2, 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      bus.enable = (k % 2 == 1);
      #1;
      n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h40 || bus.Icache2buff_valid !== 3'b000) begin n_fail++; $display("FAIL stall_hold%0d: got req=%b addr=%h valid=%b required 1/00000040/000", k, bus.mem_req_valid, bus.mem_req_addr, bus.Icache2buff_valid); end
      tick();
    end
    bus.enable = 0;
    for (int k = 0; k < 3; k++) begin
      bus.mem_req_ready = 1; #1;
      if (bus.mem_req_valid) hs++;
      tick();
    end
    bus.mem_req_ready = 0;
    n_checks++; if (hs != 1) begin n_fail++; $display("FAIL stall_accepts: got %0d handshakes required 1", hs); end
    bus.mem_resp_valid = 1; bus.mem_resp_data = 64'h0000_0044_0000_0040; tick(); bus.mem_resp_valid = 0;
    set_req(32'h40, 2, 1); #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b011 || bus.Icache2buff_data[1] !== 32'h44) begin n_fail++; $display("FAIL stall_drained: got valid=%b d1=%h required 011/00000044", bus.Icache2buff_valid, bus.Icache2buff_data[1]); end
    set_req(32'h80, 3, 0);
    tick(); tick(); #1;
    n_checks++; if (bus.icache_busy !== 1'b0 || bus.Icache2buff_valid !== 3'b000) begin n_fail++; $display("FAIL stall_nolaunch: got busy=%b valid=%b required 0/000", bus.icache_busy, bus.Icache2buff_valid); end
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    set_req(32'h100, 1, 1);
    tick();
    bus.mem_req_ready = 1; tick(); bus.mem_req_ready = 0;
    #1;
    n_checks++; if (bus.icache_busy !== 1'b1 || bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_wait: got busy=%b req=%b required 1/0", bus.icache_busy, bus.mem_req_valid); end
    #2 reset = 0;
    model_reset();
    #1;
    n_checks++; if (bus.icache_busy !== 1'b0 || bus.mem_req_addr !== 32'h0 || bus.Icache2buff_valid !== 3'b000) begin n_fail++; $display("FAIL midrst_async: got busy=%b addr=%h valid=%b required 0/0/000", bus.icache_busy, bus.mem_req_addr, bus.Icache2buff_valid); end
    bus.enable = 0;
    @(negedge clock); reset = 1;
    bus.mem_resp_valid = 1; bus.mem_resp_data = 64'hDEAD_BEEF_DEAD_BEEF; tick(); bus.mem_resp_valid = 0;
    #1;
    n_checks++; if (bus.icache_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_ignored: got busy=%b required 0", bus.icache_busy); end
    bus.enable = 1; #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b000) begin n_fail++; $display("FAIL midrst_miss: got valid=%b required 000", bus.Icache2buff_valid); end
    tick(); #1;
    n_checks++; if (bus.icache_busy !== 1'b1 || bus.mem_req_addr !== 32'h100) begin n_fail++; $display("FAIL midrst_newmiss: got busy=%b addr=%h required 1/00000100", bus.icache_busy, bus.mem_req_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_req(32'hFFFF_FFFC, 2, 1);
    #1;
    n_checks++; if (bus.Icache2buff_addr[0] !== 32'hFFFF_FFFC || bus.Icache2buff_addr[1] !== 32'h0 || bus.Icache2buff_addr[2] !== 32'h4) begin n_fail++; $display("FAIL wrap_addr: got %h required 00000004_00000000_fffffffc", bus.Icache2buff_addr); end
    tick(); #1;
    n_checks++; if (bus.mem_req_addr !== 32'hFFFF_FFF8 || bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_req1: got valid=%b addr=%h required 1/fffffff8", bus.mem_req_valid, bus.mem_req_addr); end
    serve_fill(64'h1111_FFFC_1111_FFF8);
    #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b001) begin n_fail++; $display("FAIL wrap_half: got %b required 001", bus.Icache2buff_valid); end
    tick(); #1;
    n_checks++; if (bus.mem_req_addr !== 32'h0 || bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_req2: got valid=%b addr=%h required 1/00000000", bus.mem_req_valid, bus.mem_req_addr); end
    serve_fill(64'h2222_0004_2222_0000);
    #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b011 || bus.Icache2buff_data[0] !== 32'h1111_FFFC || bus.Icache2buff_data[1] !== 32'h2222_0000) begin n_fail++; $display("FAIL wrap_full: got valid=%b data=%h required 011/..._22220000_1111fffc", bus.Icache2buff_valid, bus.Icache2buff_data); end
  endtask

  task automatic test_count_edges();
    set_req(32'h0, 0, 1); #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b000 || bus.Icache2buff_hit_count !== CW'(0)) begin n_fail++; $display("FAIL count0: got valid=%b hcnt=%0d required 000/0", bus.Icache2buff_valid, bus.Icache2buff_hit_count); end
    tick(); #1;
    n_checks++; if (bus.icache_busy !== 1'b0) begin n_fail++; $display("FAIL count0_nomiss: got busy=%b required 0", bus.icache_busy); end
    set_req(32'hFFFF_FFFC, 7, 1); #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b111 || bus.Icache2buff_hit_count !== CW'(3)) begin n_fail++; $display("FAIL count7_clamp: got valid=%b hcnt=%0d required 111/3", bus.Icache2buff_valid, bus.Icache2buff_hit_count); end
    set_req(32'h0, 4, 1); #1;
    n_checks++; if (bus.Icache2buff_valid !== 3'b011 || bus.Icache2buff_hit_count !== CW'(2)) begin n_fail++; $display("FAIL count4_clamp: got valid=%b hcnt=%0d required 011/2", bus.Icache2buff_valid, bus.Icache2buff_hit_count); end
    tick(); #1;
    n_checks++; if (bus.mem_req_addr !== 32'h8 || bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL count4_req: got valid=%b addr=%h required 1/00000008", bus.mem_req_valid, bus.mem_req_addr); end
  endtask

  task automatic test_random();
    int line;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      bus.enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) begin
        line = int'($urandom_range(0, 63));
        bus.buff2Icache_addr = (line == 63) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                            : 32'(line * 8) + 32'($urandom_range(0, 7));
      end
      bus.buff2Icache_count = CW'($urandom_range(0, (1 << CW) - 1));
      bus.mem_req_ready  = ($urandom_range(0, 1) == 1);
      bus.mem_resp_valid = ($urandom_range(0, 2) == 0);
      bus.mem_resp_data  = {$urandom, $urandom};
      #1;
      model_lookup();
      n_checks++; if (bus.Icache2buff_valid !== e_valid || bus.Icache2buff_hit_count !== CW'(e_hcnt)) begin n_fail++; $display("FAIL rnd_valid c=%0d: got valid=%b hcnt=%0d required %b/%0d", c, bus.Icache2buff_valid, bus.Icache2buff_hit_count, e_valid, e_hcnt); end
      for (int i = 0; i < N_WAY; i++) begin
        n_checks++; if (bus.Icache2buff_addr[i] !== e_addr[i] || bus.Icache2buff_data[i] !== e_data[i]) begin n_fail++; $display("FAIL rnd_lane%0d c=%0d: got addr=%h data=%h required %h/%h", i, c, bus.Icache2buff_addr[i], bus.Icache2buff_data[i], e_addr[i], e_data[i]); end
      end
      n_checks++; if (bus.mem_req_valid !== (m_phase == 1) || bus.icache_busy !== (m_phase != 0)) begin n_fail++; $display("FAIL rnd_fsm c=%0d: got req=%b busy=%b required %b/%b", c, bus.mem_req_valid, bus.icache_busy, (m_phase == 1), (m_phase != 0)); end
      if (m_phase == 1) begin
        n_checks++; if (bus.mem_req_addr !== m_fill) begin n_fail++; $display("FAIL rnd_reqaddr c=%0d: got %h required %h", c, bus.mem_req_addr, m_fill); end
      end
      tick();
    end
  endtask

  initial begin
    set_idle_inputs();
    test_reset();
    test_cold_miss();
    test_partial_hit();
    test_hole();
    test_backpressure_stall();
    test_reset_mid_fill();
    test_wrap();
    test_count_edges();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end
endmodule
